// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, round-count derivation and the GF(2^8)
// byte primitives used by both the forward and inverse iterative ciphers.
package aes_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUNDS = 2'd1,
        FINAL  = 2'd2
    } aes_fsm_e;

    function automatic int aes_nr(input int nk);
        return nk + 6;
    endfunction

    // Forward S-box, byte x at bits [8x +: 8]
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns
// (skipped for the last round), then AddRoundKey. Byte b sits at row b%4, column b/4.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [0:BLOCK_W-1] in,
    input  logic [0:BLOCK_W-1] roundKey,
    input  logic               isFinal,
    output logic [0:BLOCK_W-1] out
);

    logic [0:BLOCK_W-1] shifted;
    logic [0:BLOCK_W-1] mixed;

    genvar gi;
    generate
        // Row r is rotated left by r columns as the bytes are substituted
        for (gi = 0; gi < 16; gi++) begin : g_sub_shift
            localparam int R   = gi % 4;
            localparam int C   = gi / 4;
            localparam int SRC = 4 * ((C + R) % 4) + R;
            assign shifted[8*gi +: 8] = sbox(in[8*SRC +: 8]);
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shifted[32*gi      +: 8];
            assign a1 = shifted[32*gi + 8  +: 8];
            assign a2 = shifted[32*gi + 16 +: 8];
            assign a3 = shifted[32*gi + 24 +: 8];
            assign mixed[32*gi      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mixed[32*gi + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mixed[32*gi + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mixed[32*gi + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    assign out = (isFinal ? shifted : mixed) ^ roundKey;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption, one round per clock, with a start/busy/done handshake.
// Consumes the fully expanded key schedule; one block in flight at a time.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter  int Nk = 4,
    localparam int Nr = aes_nr(Nk)
) (
    input  logic                        clks,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [0:BLOCK_W-1]          plainText,
    input  logic [0:BLOCK_W*(Nr+1)-1]   keys,
    output logic [0:BLOCK_W-1]          cipherText,
    output logic                        busy,
    output logic                        done
);

    aes_fsm_e           fsm_q, fsm_d;
    logic [3:0]         round_q, round_d;
    logic [0:BLOCK_W-1] state_q, state_d;
    logic [0:BLOCK_W-1] cipher_q, cipher_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [0:BLOCK_W-1] round_keys [Nr+1];
    logic [0:BLOCK_W-1] round_key;
    logic [0:BLOCK_W-1] round_out;

    genvar gi;
    generate
        for (gi = 0; gi <= Nr; gi++) begin : g_key_slice
            assign round_keys[gi] = keys[BLOCK_W*gi +: BLOCK_W];
        end
    endgenerate

    assign round_key = round_keys[round_q];

    aes_enc_round u_round (
        .in       (state_q),
        .roundKey (round_key),
        .isFinal  (fsm_q == FINAL),
        .out      (round_out)
    );

    always_comb begin
        fsm_d    = fsm_q;
        round_d  = round_q;
        state_d  = state_q;
        cipher_d = cipher_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (enable) begin
                    state_d = plainText ^ round_keys[0];
                    round_d = 4'd1;
                    busy_d  = 1'b1;
                    fsm_d   = (Nr > 1) ? ROUNDS : FINAL;
                end
            end
            ROUNDS: begin
                state_d = round_out;
                round_d = round_q + 4'd1;
                if (round_q == 4'(Nr - 1)) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                cipher_d = round_out;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                round_d  = 4'd0;
                fsm_d    = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clks) begin
        if (reset) begin
            fsm_q    <= IDLE;
            round_q  <= 4'd0;
            state_q  <= '0;
            cipher_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            round_q  <= round_d;
            state_q  <= state_d;
            cipher_q <= cipher_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cipherText = cipher_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
